// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the dual-issue fetch controller
//
// Contents:
//   DEF_ADDR_W / DEF_PC_W  default ROM word-index width and byte-PC width
//   NOP_INSTR              filler instruction for invalid slots (addi x0,x0,0)
//   fetch_state_e          IDLE / RUN / HOLD; encoding is visible on the debug port
//   fetch_pair_t           one ROM pair as seen by decode: slot-1 PC, both words, slot-2 valid
package fetch_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_PC_W   = DEF_ADDR_W + 2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // The PC field is sized for the default ROM; widen DEF_ADDR_W if the ROM grows.
    typedef struct packed {
        logic [DEF_PC_W-1:0] pc;
        logic [31:0]         instr1;
        logic [31:0]         instr2;
        logic                v2;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry holding register for a stalled fetch pair
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load_i       capture pair_i (ignored when clear_i is high)
//   clear_i      drop the held pair
//   pair_i       pair to capture
//   pair_o       held pair (all zero when empty after reset/clear)
//   full_o       a pair is held
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  fetch_pair_t pair_i,
    output fetch_pair_t pair_o,
    output logic        full_o
);

    fetch_pair_t pair_q;
    logic        full_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            pair_q <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            pair_q <= pair_i;
            full_q <= 1'b1;
        end
    end

    assign pair_o = pair_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencer for the dual-issue instruction ROM
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   fetch_en                     1 = fetch, 0 = stop at a pair boundary and idle
//   redirect_valid, redirect_pc  taken branch/JAL target from EX (highest priority)
//   rom_addr                     ROM word index; ROM answers with words addr, addr+1 next cycle
//   rom_instr1, rom_instr2       ROM pair data
//   id_ready                     decode accepts the presented pair
//   if_valid1/2, if_instr1/2     presented pair; invalid slots carry NOP_INSTR
//   if_pc                        byte PC of slot 1 (slot 2 is if_pc+4)
//   fetch_state                  debug view of the FSM
module fetch_ctrl #(
    parameter int          ADDR_W    = fetch_pkg::DEF_ADDR_W,
    parameter logic [ADDR_W+1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W+1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr1,
    input  logic [31:0]       rom_instr2,
    input  logic              id_ready,
    output logic              if_valid1,
    output logic              if_valid2,
    output logic [31:0]       if_instr1,
    output logic [31:0]       if_instr2,
    output logic [ADDR_W+1:0] if_pc,
    output logic [1:0]        fetch_state
);

    import fetch_pkg::*;

    localparam int PC_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_WORD = '1;

    // Pairs advance by two words, except from the last word where only one
    // word exists, so stepping by one word wraps cleanly onto word 0.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        if (pc[PC_W-1:2] == LAST_WORD) begin
            return pc + PC_W'(4);
        end
        return pc + PC_W'(8);
    endfunction

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fpc_q, fpc_d;
    logic            fv_q, fv_d;

    logic            buf_load, buf_clear, buf_full;
    fetch_pair_t     buf_pair, cap_pair;
    logic            rom_slot2_ok;

    // Slot 2 of the pair currently leaving the ROM only exists if slot 1 is
    // not the last word.
    assign rom_slot2_ok = (fpc_q[PC_W-1:2] != LAST_WORD);

    always_comb begin
        cap_pair        = '0;
        cap_pair.pc     = fpc_q;
        cap_pair.instr1 = rom_instr1;
        cap_pair.instr2 = rom_slot2_ok ? rom_instr2 : NOP_INSTR;
        cap_pair.v2     = rom_slot2_ok;
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pair_i  (cap_pair),
        .pair_o  (buf_pair),
        .full_o  (buf_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fpc_q   <= RESET_PC;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fpc_q   <= fpc_d;
            fv_q    <= fv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fpc_d     = fpc_q;
        fv_d      = fv_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;

        if (redirect_valid) begin
            // The pair on the outputs this cycle is squashed by EX, so any
            // acceptance is harmless; everything in flight is dropped.
            pc_d      = {redirect_pc[PC_W-1:2], 2'b00};
            fv_d      = 1'b0;
            buf_clear = 1'b1;
            state_d   = fetch_en ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    fv_d = 1'b0;
                    if (fetch_en) begin
                        state_d = RUN;
                        fv_d    = 1'b1;
                        fpc_d   = pc_q;
                        pc_d    = next_pc(pc_q);
                    end
                end
                RUN: begin
                    if (!fetch_en) begin
                        // Restart from the oldest pair decode has not taken.
                        pc_d      = (fv_q && !id_ready) ? fpc_q : pc_q;
                        fv_d      = 1'b0;
                        buf_clear = 1'b1;
                        state_d   = IDLE;
                    end else if (!fv_q || id_ready) begin
                        fpc_d = pc_q;
                        fv_d  = 1'b1;
                        pc_d  = next_pc(pc_q);
                    end else begin
                        // Park the stalled pair; the ROM keeps reading pc_q so
                        // the following pair is ready the cycle decode frees up.
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (!fetch_en) begin
                        pc_d      = id_ready ? pc_q : buf_pair.pc[PC_W-1:0];
                        fv_d      = 1'b0;
                        buf_clear = 1'b1;
                        state_d   = IDLE;
                    end else if (id_ready) begin
                        buf_clear = 1'b1;
                        state_d   = RUN;
                        fpc_d     = pc_q;
                        fv_d      = 1'b1;
                        pc_d      = next_pc(pc_q);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    fv_d      = 1'b0;
                    buf_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        if_valid1 = 1'b0;
        if_valid2 = 1'b0;
        if_instr1 = NOP_INSTR;
        if_instr2 = NOP_INSTR;
        if_pc     = fpc_q;
        if (state_q == HOLD) begin
            if_pc     = buf_pair.pc[PC_W-1:0];
            if_valid1 = buf_full;
            if_valid2 = buf_full && buf_pair.v2;
            if (buf_full) begin
                if_instr1 = buf_pair.instr1;
            end
            if (buf_full && buf_pair.v2) begin
                if_instr2 = buf_pair.instr2;
            end
        end else begin
            if_valid1 = fv_q;
            if_valid2 = fv_q && rom_slot2_ok;
            if (fv_q) begin
                if_instr1 = rom_instr1;
            end
            if (fv_q && rom_slot2_ok) begin
                if_instr2 = rom_instr2;
            end
        end
    end

    assign rom_addr    = pc_q[PC_W-1:2];
    assign fetch_state = state_q;

endmodule
